// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared types and glyph constants for the seven-segment display path.
// Revision : 1.0
// ============================================================================
package seg7_pkg;

   typedef enum logic [0:0] {
      ST_LAMP = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_ALL   = 7'h7F;

   // Active-high glyphs, bit0 = segment a ... bit6 = segment g.
   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational nibble-to-segment decode with blanking and polarity.
// Revision : 1.0
// ============================================================================
module seg7_decode
   import seg7_pkg::*;
#(
   parameter int ACTIVE_LOW = 1
) (
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   logic [6:0] w_seg_hi;

   always_comb begin
      w_seg_hi = blank_i ? SEG_BLANK : GLYPH[nibble_i];
   end

   assign seg_o = (ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;

endmodule
`default_nettype wire

// File: rtl/seg7_hex_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_hex_display
// Purpose  : Registered HEX digit-bank controller: lamp test, hex decode,
//            leading-zero blanking, per-digit blink (built with SEG7_BLINK_EN).
// Revision : 1.0
// ============================================================================
module seg7_hex_display
   import seg7_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int CLK_HZ      = 50_000_000,
   parameter int BLINK_HZ    = 2,
   parameter int LAMP_CYCLES = 25_000_000,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET,
   input  logic                  WR_VALID,
   output logic                  WR_READY,
   input  logic [4*DIGITS-1:0]   WR_DATA,
   input  logic                  WR_LZB,
   input  logic [DIGITS-1:0]     WR_BLINK,
   output logic [7*DIGITS-1:0]   HEX_OUT
);

   localparam int                LAMP_W      = (LAMP_CYCLES > 1) ? $clog2(LAMP_CYCLES) : 1;
   localparam logic [LAMP_W-1:0] LAMP_LAST   = LAMP_W'(LAMP_CYCLES - 1);
   localparam logic [7*DIGITS-1:0] HEX_ALL_LIT = {(7*DIGITS){(ACTIVE_LOW == 0)}};

   state_e                state_q, state_d;
   logic [LAMP_W-1:0]     lamp_cnt_q, lamp_cnt_d;
   logic [4*DIGITS-1:0]   data_q;
   logic                  lzb_q;
   logic [DIGITS-1:0]     blink_q;
   logic [7*DIGITS-1:0]   hex_q, hex_d;
   logic                  w_accept;
   logic                  w_phase;
   logic                  w_lead;
   logic [DIGITS-1:0]     w_blank;
   logic [7*DIGITS-1:0]   w_seg;

   assign WR_READY = (state_q == ST_RUN);
   assign w_accept = WR_VALID & WR_READY;
   assign HEX_OUT  = hex_q;

   always_comb begin
      state_d    = state_q;
      lamp_cnt_d = lamp_cnt_q;
      if (state_q == ST_LAMP) begin
         if (lamp_cnt_q == LAMP_LAST) begin
            state_d = ST_RUN;
         end else begin
            lamp_cnt_d = lamp_cnt_q + LAMP_W'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_LAMP;
         lamp_cnt_q <= '0;
         data_q     <= '0;
         lzb_q      <= 1'b0;
         blink_q    <= '0;
         hex_q      <= HEX_ALL_LIT;
      end else begin
         state_q    <= state_d;
         lamp_cnt_q <= lamp_cnt_d;
         hex_q      <= hex_d;
         if (w_accept) begin
            data_q  <= WR_DATA;
            lzb_q   <= WR_LZB;
            blink_q <= WR_BLINK;
         end
      end
   end

`ifdef SEG7_BLINK_EN
   localparam int               HALF_P   = (CLK_HZ / (2 * BLINK_HZ) > 1) ? CLK_HZ / (2 * BLINK_HZ) : 1;
   localparam int               PRE_W    = (HALF_P > 1) ? $clog2(HALF_P) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(HALF_P - 1);

   logic [PRE_W-1:0] pre_cnt_q;
   logic             phase_q;

   // Prescaler parks at zero during the lamp test; the phase survives writes.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         pre_cnt_q <= '0;
         phase_q   <= 1'b0;
      end else if (state_q == ST_RUN) begin
         if (pre_cnt_q == PRE_LAST) begin
            pre_cnt_q <= '0;
            phase_q   <= ~phase_q;
         end else begin
            pre_cnt_q <= pre_cnt_q + PRE_W'(1);
         end
      end else begin
         pre_cnt_q <= '0;
      end
   end

   assign w_phase = phase_q;
`else
   assign w_phase = 1'b0;
`endif

   // Leading zeros blank from the top digit down; digit 0 always shows.
   always_comb begin
      w_lead  = lzb_q;
      w_blank = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if ((i > 0) && w_lead && (data_q[4*i +: 4] == 4'h0)) begin
            w_blank[i] = 1'b1;
         end else begin
            w_lead = 1'b0;
         end
         w_blank[i] = w_blank[i] | (blink_q[i] & w_phase);
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      seg7_decode #(
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_decode (
         .nibble_i (data_q[4*g +: 4]),
         .blank_i  (w_blank[g]),
         .seg_o    (w_seg[7*g +: 7])
      );
   end

   assign hex_d = (state_q == ST_LAMP) ? HEX_ALL_LIT : w_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg7_hex_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_hex_display
// Purpose  : Directed, table-driven checks of seg7_hex_display (4 digits, active-low).
// Revision : 1.0
// ============================================================================
module tb_seg7_hex_display;

   logic        CLOCK_50;
   logic        RESET;
   logic        WR_VALID;
   logic        WR_READY;
   logic [15:0] WR_DATA;
   logic        WR_LZB;
   logic [3:0]  WR_BLINK;
   logic [27:0] HEX_OUT;

   int n_pass  = 0;
   int n_total = 0;

   seg7_hex_display #(
      .DIGITS      (4),
      .CLK_HZ      (16),
      .BLINK_HZ    (2),
      .LAMP_CYCLES (8),
      .ACTIVE_LOW  (1)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .WR_VALID (WR_VALID),
      .WR_READY (WR_READY),
      .WR_DATA  (WR_DATA),
      .WR_LZB   (WR_LZB),
      .WR_BLINK (WR_BLINK),
      .HEX_OUT  (HEX_OUT)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      string       name;
      logic [15:0] data;
      logic        lzb;
      logic [27:0] exp;
   } vec_t;

   vec_t vecs [10];

   function automatic logic [27:0] hx(input logic [6:0] d3, input logic [6:0] d2,
                                      input logic [6:0] d1, input logic [6:0] d0);
      return {d3, d2, d1, d0};
   endfunction

   task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Call at a negedge with RESET high; returns at the negedge after edge 10.
   task automatic lamp_seq(input string tag);
      WR_VALID = 1'b1;
      WR_DATA  = 16'hFFFF;
      WR_LZB   = 1'b0;
      WR_BLINK = 4'hF;
      RESET    = 1'b0;
      chk({tag, "_ready_c0"}, {27'd0, WR_READY}, 28'd0);
      chk({tag, "_hex_c0"}, HEX_OUT, 28'd0);
      for (int i = 1; i <= 7; i++) begin
         @(negedge CLOCK_50);
         chk($sformatf("%s_ready_c%0d", tag, i), {27'd0, WR_READY}, 28'd0);
         chk($sformatf("%s_hex_c%0d", tag, i), HEX_OUT, 28'd0);
      end
      @(posedge CLOCK_50);
      #1 WR_VALID = 1'b0;
      @(negedge CLOCK_50);
      chk({tag, "_ready_run"}, {27'd0, WR_READY}, 28'd1);
      chk({tag, "_hex_edge8"}, HEX_OUT, 28'd0);
      @(negedge CLOCK_50);
      chk({tag, "_hex_zero9"}, HEX_OUT, hx(7'h40, 7'h40, 7'h40, 7'h40));
      @(negedge CLOCK_50);
      chk({tag, "_hex_zero10"}, HEX_OUT, hx(7'h40, 7'h40, 7'h40, 7'h40));
   endtask

   // Call at a negedge; checks the value two edges after acceptance.
   task automatic do_write(input string name, input logic [15:0] d, input logic lzb,
                           input logic [27:0] exp);
      WR_VALID = 1'b1;
      WR_DATA  = d;
      WR_LZB   = lzb;
      WR_BLINK = 4'h0;
      @(posedge CLOCK_50);
      #1 WR_VALID = 1'b0;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      chk(name, HEX_OUT, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        blink_on;
      logic        ph;
      logic [6:0]  d0;

      vecs[0] = '{"hex_12AF",   16'h12AF, 1'b0, hx(7'h79, 7'h24, 7'h08, 7'h0E)};
      vecs[1] = '{"lzb_0070",   16'h0070, 1'b1, hx(7'h7F, 7'h7F, 7'h78, 7'h40)};
      vecs[2] = '{"lzb_0000",   16'h0000, 1'b1, hx(7'h7F, 7'h7F, 7'h7F, 7'h40)};
      vecs[3] = '{"nolzb_0000", 16'h0000, 1'b0, hx(7'h40, 7'h40, 7'h40, 7'h40)};
      vecs[4] = '{"lzb_0305",   16'h0305, 1'b1, hx(7'h7F, 7'h30, 7'h40, 7'h12)};
      vecs[5] = '{"hex_89CD",   16'h89CD, 1'b0, hx(7'h00, 7'h10, 7'h46, 7'h21)};
      vecs[6] = '{"lzb_1000",   16'h1000, 1'b1, hx(7'h79, 7'h40, 7'h40, 7'h40)};
      vecs[7] = '{"lzb_0B06",   16'h0B06, 1'b1, hx(7'h7F, 7'h03, 7'h40, 7'h02)};
      vecs[8] = '{"hex_E000",   16'hE000, 1'b0, hx(7'h06, 7'h40, 7'h40, 7'h40)};
      vecs[9] = '{"lzb_0004",   16'h0004, 1'b1, hx(7'h7F, 7'h7F, 7'h7F, 7'h19)};

`ifdef SEG7_BLINK_EN
      blink_on = 1'b1;
`else
      blink_on = 1'b0;
`endif

      RESET    = 1'b1;
      WR_VALID = 1'b0;
      WR_DATA  = 16'h0000;
      WR_LZB   = 1'b0;
      WR_BLINK = 4'h0;
      repeat (2) @(negedge CLOCK_50);
      chk("reset_hex", HEX_OUT, 28'd0);
      chk("reset_ready", {27'd0, WR_READY}, 28'd0);

      lamp_seq("lamp1");

      for (int i = 0; i < 10; i++) begin
         do_write(vecs[i].name, vecs[i].data, vecs[i].lzb, vecs[i].exp);
      end

      // Back-to-back writes: the second one wins.
      WR_VALID = 1'b1;
      WR_DATA  = 16'h12AF;
      WR_LZB   = 1'b0;
      @(posedge CLOCK_50);
      #1;
      WR_DATA  = 16'h0070;
      WR_LZB   = 1'b1;
      @(posedge CLOCK_50);
      #1 WR_VALID = 1'b0;
      @(negedge CLOCK_50);
      chk("b2b_first", HEX_OUT, hx(7'h79, 7'h24, 7'h08, 7'h0E));
      @(negedge CLOCK_50);
      chk("b2b_last", HEX_OUT, hx(7'h7F, 7'h7F, 7'h78, 7'h40));

      // Fresh reset so the blink phase is aligned to RUN entry at edge 8.
      RESET = 1'b1;
      @(negedge CLOCK_50);
      lamp_seq("lamp2");
      WR_VALID = 1'b1;
      WR_DATA  = 16'h1111;
      WR_LZB   = 1'b0;
      WR_BLINK = 4'b0001;
      @(posedge CLOCK_50);
      #1 WR_VALID = 1'b0;
      @(negedge CLOCK_50);
      for (int e = 12; e <= 27; e++) begin
         @(negedge CLOCK_50);
         ph = blink_on & (((e - 9) / 4) % 2 == 1);
         d0 = ph ? 7'h7F : 7'h79;
         chk($sformatf("blink_e%0d", e), HEX_OUT, hx(7'h79, 7'h79, 7'h79, d0));
      end

      // Asynchronous reset between clock edges.
      #2 RESET = 1'b1;
      #1;
      chk("async_rst_hex", HEX_OUT, 28'd0);
      chk("async_rst_ready", {27'd0, WR_READY}, 28'd0);
      @(negedge CLOCK_50);
      lamp_seq("lamp3");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
